iq_lockin_accum: RTL and testbench

- Lock-in demodulator directly downstream of the sin/cos DDS.
- Multiplies each signed ADC sample by the DDS sine and cosine references.
- Accumulates the I and Q products over an integer number of reference periods, delimited by the DDS zero-crossing pulse.
- Presents the I/Q sums and the sample count to the measurement controller, e.g. for impedance magnitude/phase computation.

---
 rtl/iq_lockin_accum.sv | 171 +++++++++++++++++
 tb/tb_iq_lockin_accum.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_lockin_accum.sv
// iq_lockin_accum: lock-in I/Q demodulator that integrates adc*sin and adc*cos over N reference periods.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start_i             : one-cycle measurement request, ignored while busy_o
//   n_periods_i         : periods to integrate, 0 treated as 1, sampled on accepted start
//   adc_i/sin_i/cos_i   : signed sample and references, time-aligned
//   ref_valid_i         : sample qualifier, invalid cycles are ignored entirely
//   period_pulse_i      : marks the first sample of a reference period
//   i_acc_o/q_acc_o     : saturated signed sums of adc*sin / adc*cos
//   sample_cnt_o        : number of samples integrated
//   result_valid_o      : one-cycle strobe, outputs updated in the same cycle
//   busy_o              : measurement in progress
//   overflow_o          : an accumulator saturated during the reported measurement
module iq_lockin_accum #(
    parameter int DATA_W = 14,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 32,
    parameter int NPER_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [NPER_W-1:0]        n_periods_i,
    input  logic signed [DATA_W-1:0] adc_i,
    input  logic signed [DATA_W-1:0] sin_i,
    input  logic signed [DATA_W-1:0] cos_i,
    input  logic                     ref_valid_i,
    input  logic                     period_pulse_i,
    output logic signed [ACC_W-1:0]  i_acc_o,
    output logic signed [ACC_W-1:0]  q_acc_o,
    output logic [CNT_W-1:0]         sample_cnt_o,
    output logic                     result_valid_o,
    output logic                     busy_o,
    output logic                     overflow_o
);
    localparam int PW = 2 * DATA_W;
    localparam int XW = ACC_W + 1 - PW;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ARM, ACCUM, FLUSH, DONE} state_t;

    state_t state, state_n;
    logic flush_last;
    logic accept, incl, done, pulse, term;
    logic [NPER_W-1:0] n_lat, pcnt;
    logic s1_inc, s2_inc;
    logic signed [DATA_W-1:0] s1_adc, s1_sin, s1_cos;
    logic signed [PW-1:0] prod_i, prod_q;
    logic signed [ACC_W-1:0] i_acc, q_acc;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    logic [ACC_W:0] i_sum, q_sum;
    logic [ACC_W-1:0] i_sat, q_sat;
    logic i_ovf, q_ovf;

    assign pulse = period_pulse_i & ref_valid_i;
    // The pulse that would make the period count reach N closes the window.
    assign term  = (pcnt + NPER_W'(1)) == n_lat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start_i ? ARM : IDLE;
            ARM:     state_n = pulse ? ACCUM : ARM;
            ACCUM:   state_n = (pulse && term) ? FLUSH : ACCUM;
            FLUSH:   state_n = flush_last ? DONE : FLUSH;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && start_i;
        incl   = ref_valid_i && (((state == ARM) && period_pulse_i) ||
                                 ((state == ACCUM) && !(period_pulse_i && term)));
        done   = (state == DONE);
    end

    // Second of the two FLUSH cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flush_last <= 1'b0;
        else          flush_last <= (state == FLUSH) && !flush_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_lat <= '0;
            pcnt  <= '0;
        end else if (accept) begin
            n_lat <= (n_periods_i == '0) ? NPER_W'(1) : n_periods_i;
            pcnt  <= '0;
        end else if ((state == ACCUM) && pulse) begin
            pcnt  <= pcnt + NPER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_inc <= 1'b0;
            s1_adc <= '0;
            s1_sin <= '0;
            s1_cos <= '0;
            s2_inc <= 1'b0;
            prod_i <= '0;
            prod_q <= '0;
        end else begin
            s1_inc <= incl;
            s1_adc <= adc_i;
            s1_sin <= sin_i;
            s1_cos <= cos_i;
            s2_inc <= s1_inc;
            prod_i <= PW'(s1_adc) * PW'(s1_sin);
            prod_q <= PW'(s1_adc) * PW'(s1_cos);
        end
    end

    // One guard bit above the accumulator: overflow when it disagrees with the sign bit.
    always_comb begin
        i_sum = {i_acc[ACC_W-1], i_acc} + {{XW{prod_i[PW-1]}}, prod_i};
        q_sum = {q_acc[ACC_W-1], q_acc} + {{XW{prod_q[PW-1]}}, prod_q};
        i_ovf = i_sum[ACC_W] ^ i_sum[ACC_W-1];
        q_ovf = q_sum[ACC_W] ^ q_sum[ACC_W-1];
        i_sat = i_ovf ? (i_sum[ACC_W] ? ACC_MIN : ACC_MAX) : i_sum[ACC_W-1:0];
        q_sat = q_ovf ? (q_sum[ACC_W] ? ACC_MIN : ACC_MAX) : q_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_acc <= '0;
            q_acc <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            i_acc <= '0;
            q_acc <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (s2_inc) begin
            i_acc <= i_sat;
            q_acc <= q_sat;
            cnt   <= (&cnt) ? cnt : cnt + CNT_W'(1);
            ovf   <= ovf | i_ovf | q_ovf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_acc_o        <= '0;
            q_acc_o        <= '0;
            sample_cnt_o   <= '0;
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            result_valid_o <= done;
            busy_o         <= (state_n != IDLE);
            if (accept) overflow_o <= 1'b0;
            if (done) begin
                i_acc_o      <= i_acc;
                q_acc_o      <= q_acc;
                sample_cnt_o <= cnt;
                overflow_o   <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_iq_lockin_accum.sv
// tb_iq_lockin_accum: randomized and directed checks of iq_lockin_accum against a cycle-level behavioural model.
module tb_iq_lockin_accum;
    localparam int DW = 14;
    localparam int AW = 30;
    localparam int CW = 32;
    localparam int NW = 16;
    localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (AW - 1));

    logic clk = 1'b0;
    logic reset_n, start_i, ref_valid_i, period_pulse_i;
    logic [NW-1:0] n_periods_i;
    logic signed [DW-1:0] adc_i, sin_i, cos_i;
    logic signed [AW-1:0] i_acc_o, q_acc_o;
    logic [CW-1:0] sample_cnt_o;
    logic result_valid_o, busy_o, overflow_o;

    int vectors = 0, miscompares = 0;
    bit chk_en = 0;

    // Model-visible expected outputs.
    longint e_i = 0, e_q = 0, e_cnt = 0;
    bit e_rv = 0, e_busy = 0, e_ovf = 0;
    // Model measurement state: 0 idle, 1 waiting first pulse, 2 integrating, 3 waiting for result.
    int mst = 0, nl = 1, pc = 0, cd = 0;
    longint si = 0, sq = 0, sc = 0;
    bit so = 0;

    iq_lockin_accum #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .NPER_W(NW)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .n_periods_i(n_periods_i),
        .adc_i(adc_i), .sin_i(sin_i), .cos_i(cos_i), .ref_valid_i(ref_valid_i),
        .period_pulse_i(period_pulse_i), .i_acc_o(i_acc_o), .q_acc_o(q_acc_o),
        .sample_cnt_o(sample_cnt_o), .result_valid_o(result_valid_o), .busy_o(busy_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_sample();
        si = si + longint'(adc_i) * longint'(sin_i);
        sq = sq + longint'(adc_i) * longint'(cos_i);
        if (si > AMAX) begin si = AMAX; so = 1; end
        if (si < AMIN) begin si = AMIN; so = 1; end
        if (sq > AMAX) begin sq = AMAX; so = 1; end
        if (sq < AMIN) begin sq = AMIN; so = 1; end
        sc++;
    endtask

    always begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mst = 0; e_i = 0; e_q = 0; e_cnt = 0; e_rv = 0; e_busy = 0; e_ovf = 0;
        end else begin
            e_rv = 0;
            case (mst)
                0: if (start_i) begin
                    nl = (n_periods_i == 0) ? 1 : int'(n_periods_i);
                    si = 0; sq = 0; sc = 0; so = 0;
                    e_ovf = 0; e_busy = 1; mst = 1;
                end
                1: if (ref_valid_i && period_pulse_i) begin
                    pc = 0; add_sample(); mst = 2;
                end
                2: if (ref_valid_i) begin
                    if (period_pulse_i) begin
                        pc++;
                        if (pc == nl) begin cd = 3; mst = 3; end
                        else add_sample();
                    end else add_sample();
                end
                default: begin
                    cd--;
                    if (cd == 0) begin
                        e_i = si; e_q = sq; e_cnt = sc; e_ovf = so;
                        e_rv = 1; e_busy = 0; mst = 0;
                    end
                end
            endcase
        end
    end

    always begin
        @(negedge clk);
        if (chk_en) begin
            chk("result_valid", result_valid_o, e_rv);
            chk("busy", busy_o, e_busy);
            chk("overflow", overflow_o, e_ovf);
            chk("i_acc", i_acc_o, e_i);
            chk("q_acc", q_acc_o, e_q);
            chk("sample_cnt", sample_cnt_o, e_cnt);
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            start_i = 0;
            ref_valid_i = 1'($urandom_range(0, 1));
            period_pulse_i = 1'($urandom_range(0, 1));
            adc_i = DW'($urandom); sin_i = DW'($urandom); cos_i = DW'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input int n, input int per, input bit gaps, input bit rnd, input bit pstart,
                       input int a, input int s, input int c, input int restart_k, input int reset_k,
                       output bit done, output int lat);
        int vc = 0, term_k = 0;
        bit v;
        done = 0; lat = -1;
        start_i = 1; n_periods_i = NW'(n);
        ref_valid_i = 1; period_pulse_i = pstart;
        adc_i = rnd ? DW'($urandom) : DW'(a);
        sin_i = rnd ? DW'($urandom) : DW'(s);
        cos_i = rnd ? DW'($urandom) : DW'(c);
        @(posedge clk); #1;
        for (int k = 0; k < 3000; k++) begin
            if (result_valid_o) begin done = 1; lat = k - term_k; break; end
            if (k == reset_k) begin
                reset_n = 0; start_i = 0;
                repeat (2) @(posedge clk);
                #1 reset_n = 1;
                break;
            end
            start_i = (k == restart_k);
            n_periods_i = (k == restart_k) ? NW'(7) : NW'($urandom);
            v = gaps ? (k % 2 == 0) : rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            ref_valid_i = v;
            if (v) begin
                period_pulse_i = (vc % per == 0);
                if (vc % per == 0) term_k = k;
                vc++;
            end else period_pulse_i = gaps ? 1'b1 : 1'($urandom_range(0, 1));
            adc_i = rnd ? DW'($urandom) : DW'(a);
            sin_i = rnd ? DW'($urandom) : DW'(s);
            cos_i = rnd ? DW'($urandom) : DW'(c);
            @(posedge clk); #1;
        end
        start_i = 0; ref_valid_i = 0; period_pulse_i = 0;
        if (reset_k < 0) chk("run_done", done, 1);
    endtask

    task automatic pin(input string tag, input longint ei, input longint eq, input longint ec, input longint eo);
        chk({tag, "_model_i"}, e_i, ei);
        chk({tag, "_model_q"}, e_q, eq);
        chk({tag, "_model_cnt"}, e_cnt, ec);
        chk({tag, "_dut_i"}, i_acc_o, ei);
        chk({tag, "_dut_q"}, q_acc_o, eq);
        chk({tag, "_dut_cnt"}, sample_cnt_o, ec);
        chk({tag, "_dut_ovf"}, overflow_o, eo);
    endtask

    initial begin
        bit done;
        int lat;
        reset_n = 1; start_i = 0; n_periods_i = '0; ref_valid_i = 0; period_pulse_i = 0;
        adc_i = '0; sin_i = '0; cos_i = '0;
        #2 reset_n = 0;
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        pin("reset", 0, 0, 0, 0);
        chk("reset_busy", busy_o, 0);
        idle(5);

        run(2, 8, 0, 0, 0, 20, 100, -50, -1, -1, done, lat);
        pin("const", 32000, -16000, 16, 0);
        chk("const_latency", lat, 4);
        idle(3);

        run(2, 8, 1, 0, 0, 20, 100, -50, -1, -1, done, lat);
        pin("gaps", 32000, -16000, 16, 0);
        chk("gaps_latency", lat, 4);
        idle(3);

        run(0, 4, 0, 0, 0, -3, 7, 1, -1, -1, done, lat);
        pin("nper0", -84, -12, 4, 0);
        idle(3);

        run(1, 16, 0, 0, 0, 8191, 8191, 8191, -1, -1, done, lat);
        pin("sat", 536870911, 536870911, 16, 1);
        idle(3);

        run(1, 4, 0, 0, 0, 1, 2, 3, -1, -1, done, lat);
        pin("sat_clear", 8, 12, 4, 0);
        idle(3);

        run(2, 8, 0, 0, 0, 20, 100, -50, 5, -1, done, lat);
        pin("busy_ignore", 32000, -16000, 16, 0);
        idle(3);

        run(2, 8, 0, 1, 1, 0, 0, 0, -1, -1, done, lat);
        idle(3);

        run(2, 8, 0, 0, 0, 20, 100, -50, -1, 10, done, lat);
        chk("reset_mid_done", done, 0);
        pin("reset_mid", 0, 0, 0, 0);
        chk("reset_mid_busy", busy_o, 0);
        idle(3);

        run(2, 8, 0, 0, 0, 20, 100, -50, -1, -1, done, lat);
        pin("after_reset", 32000, -16000, 16, 0);
        idle(3);

        for (int r = 0; r < 10; r++) begin
            run($urandom_range(0, 3), $urandom_range(3, 10), 1'($urandom_range(0, 1)), 1,
                1'($urandom_range(0, 1)), 0, 0, 0, (r == 4) ? 6 : -1, -1, done, lat);
            idle($urandom_range(1, 6));
        end

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
